vga_scan_timing: RTL and testbench

Upstream stage of the display pipeline: divides `OriginalClk` down to the pixel rate and generates the 640x480@60 scan. Drives `XPosition`/`YPosition` into every layer renderer (track line, notes, HUD) and produces HSync, VSync and Visible. These three outputs are delayed to line up with the renderers' registered `LayerOutput`, so the compositor and VGA pins see aligned pixel and sync data.

---
 rtl/vga_scan_timing.sv | 128 ++++++++++++
 tb/tb_vga_scan_timing.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/vga_scan_timing.sv
// vga_scan_timing: pixel-rate divider and 640x480@60 scan counters.
// Optional FrameCount output when FRAME_COUNT_EN is defined.
module vga_scan_timing #(
  parameter int CLK_DIV    = 4,
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int PIPE_DELAY = 1
) (
  input  logic        OriginalClk,
  input  logic        Reset,
  output logic [9:0]  XPosition,
  output logic [9:0]  YPosition,
  output logic        PixelTick,
  output logic        HSync,
  output logic        VSync,
  output logic        Visible,
  output logic        FrameStart
`ifdef FRAME_COUNT_EN
  ,
  output logic [15:0] FrameCount
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HS_LO   = H_VISIBLE + H_FRONT;
  localparam int HS_HI   = H_VISIBLE + H_FRONT + H_SYNC;
  localparam int VS_LO   = V_VISIBLE + V_FRONT;
  localparam int VS_HI   = V_VISIBLE + V_FRONT + V_SYNC;

  // {hsync, vsync, visible} inactive pattern
  localparam logic [2:0] SYNC_IDLE = 3'b110;

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_nxt;
  logic          div_last;
  logic          line_end;
  logic          frame_end;
  logic [9:0]    x_nxt;
  logic [9:0]    y_nxt;
  logic [2:0]    sync_nxt;
  logic [2:0]    sync_raw;

  assign div_last  = (div_q == DW'(CLK_DIV - 1));
  assign div_nxt   = div_last ? '0 : div_q + DW'(1);
  assign line_end  = (XPosition == 10'(H_TOTAL - 1));
  assign frame_end = line_end && (YPosition == 10'(V_TOTAL - 1));

  // next scan position, advancing only on the last divider phase
  always_comb begin
    x_nxt = XPosition;
    y_nxt = YPosition;
    if (div_last) begin
      if (line_end) begin
        x_nxt = '0;
        y_nxt = frame_end ? '0 : YPosition + 10'd1;
      end else begin
        x_nxt = XPosition + 10'd1;
      end
    end
  end

  // sync/visible decode of the position the counters are about to take
  always_comb begin
    sync_nxt[2] = !((x_nxt >= 10'(HS_LO)) && (x_nxt < 10'(HS_HI)));
    sync_nxt[1] = !((y_nxt >= 10'(VS_LO)) && (y_nxt < 10'(VS_HI)));
    sync_nxt[0] = (x_nxt < 10'(H_VISIBLE)) && (y_nxt < 10'(V_VISIBLE));
  end

  // divider, counters, strobes and undelayed sync, all in one register bank
  always_ff @(posedge OriginalClk or posedge Reset) begin
    if (Reset) begin
      div_q      <= '0;
      XPosition  <= '0;
      YPosition  <= '0;
      PixelTick  <= 1'b0;
      FrameStart <= 1'b0;
      sync_raw   <= SYNC_IDLE;
`ifdef FRAME_COUNT_EN
      FrameCount <= '0;
`endif
    end else begin
      div_q      <= div_nxt;
      PixelTick  <= (div_nxt == DW'(CLK_DIV - 1));
      FrameStart <= div_last && frame_end;
      if (div_last) begin
        XPosition <= x_nxt;
        YPosition <= y_nxt;
        sync_raw  <= sync_nxt;
      end
`ifdef FRAME_COUNT_EN
      if (div_last && frame_end) FrameCount <= FrameCount + 16'd1;
`endif
    end
  end

  generate
    if (PIPE_DELAY == 0) begin : g_nodly
      assign HSync   = sync_raw[2];
      assign VSync   = sync_raw[1];
      assign Visible = sync_raw[0];
    end else begin : g_dly
      logic [2:0] pipe [PIPE_DELAY];

      // align sync/visible with the renderers' registered layer output
      always_ff @(posedge OriginalClk or posedge Reset) begin
        if (Reset) begin
          for (int i = 0; i < PIPE_DELAY; i++) pipe[i] <= SYNC_IDLE;
        end else begin
          pipe[0] <= sync_raw;
          for (int i = 1; i < PIPE_DELAY; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign HSync   = pipe[PIPE_DELAY-1][2];
      assign VSync   = pipe[PIPE_DELAY-1][1];
      assign Visible = pipe[PIPE_DELAY-1][0];
    end
  endgenerate

endmodule

// File: tb/tb_vga_scan_timing.sv
// tb_vga_scan_timing: three scan generators checked each cycle
// against a closed-form model of pixel index versus elapsed cycles.
module tb_vga_scan_timing;

  typedef struct {
    int d, hv, hf, hs, hb, vv, vf, vs, vb, p;
  } cfg_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] x [3];
  logic [9:0] y [3];
  logic tk [3];
  logic hs [3];
  logic vs [3];
  logic vi [3];
  logic fs [3];
`ifdef FRAME_COUNT_EN
  logic [15:0] fc [3];
`endif

  cfg_t cfg [3];
  int errs = 0;
  int checks = 0;
  longint k = 0;
  bit in_rst = 1'b1;

  vga_scan_timing u_a (
    .OriginalClk(clk), .Reset(rst),
    .XPosition(x[0]), .YPosition(y[0]), .PixelTick(tk[0]),
    .HSync(hs[0]), .VSync(vs[0]), .Visible(vi[0]),
    .FrameStart(fs[0])
`ifdef FRAME_COUNT_EN
    , .FrameCount(fc[0])
`endif
  );

  vga_scan_timing #(
    .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .PIPE_DELAY(0)
  ) u_b (
    .OriginalClk(clk), .Reset(rst),
    .XPosition(x[1]), .YPosition(y[1]), .PixelTick(tk[1]),
    .HSync(hs[1]), .VSync(vs[1]), .Visible(vi[1]),
    .FrameStart(fs[1])
`ifdef FRAME_COUNT_EN
    , .FrameCount(fc[1])
`endif
  );

  vga_scan_timing #(
    .CLK_DIV(3), .H_VISIBLE(5), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .PIPE_DELAY(3)
  ) u_c (
    .OriginalClk(clk), .Reset(rst),
    .XPosition(x[2]), .YPosition(y[2]), .PixelTick(tk[2]),
    .HSync(hs[2]), .VSync(vs[2]), .Visible(vi[2]),
    .FrameStart(fs[2])
`ifdef FRAME_COUNT_EN
    , .FrameCount(fc[2])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s got=%0d want=%0d (k=%0d)", tag, obs, exp, k);
    end
  endtask

  // {hsync, vsync, visible} of the undelayed decode after kk edges
  function automatic logic [2:0] raw_sync(cfg_t c, longint kk);
    longint pix, px, py, ht, vt;
    logic h, v, e;
    if (kk < c.d) return 3'b110;
    ht  = c.hv + c.hf + c.hs + c.hb;
    vt  = c.vv + c.vf + c.vs + c.vb;
    pix = kk / c.d;
    px  = pix % ht;
    py  = (pix / ht) % vt;
    h = !(px >= c.hv + c.hf && px < c.hv + c.hf + c.hs);
    v = !(py >= c.vv + c.vf && py < c.vv + c.vf + c.vs);
    e = (px < c.hv) && (py < c.vv);
    return {h, v, e};
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      cfg_t c;
      longint ht, vt, pix, ex, ey, efc;
      logic et, efs;
      logic [2:0] es;
      c  = cfg[i];
      ht = c.hv + c.hf + c.hs + c.hb;
      vt = c.vv + c.vf + c.vs + c.vb;
      if (in_rst) begin
        ex = 0; ey = 0; et = 0; efs = 0; efc = 0; es = 3'b110;
      end else begin
        pix = k / c.d;
        ex  = pix % ht;
        ey  = (pix / ht) % vt;
        et  = (k % c.d) == c.d - 1;
        efs = pix > 0 && (k % c.d) == 0 && (pix % (ht * vt)) == 0;
        efc = (pix / (ht * vt)) % 65536;
        es  = raw_sync(c, k - c.p);
      end
      chk($sformatf("u%0d.x", i), 32'(x[i]), 32'(ex));
      chk($sformatf("u%0d.y", i), 32'(y[i]), 32'(ey));
      chk($sformatf("u%0d.tick", i), 32'(tk[i]), 32'(et));
      chk($sformatf("u%0d.hsync", i), 32'(hs[i]), 32'(es[2]));
      chk($sformatf("u%0d.vsync", i), 32'(vs[i]), 32'(es[1]));
      chk($sformatf("u%0d.visible", i), 32'(vi[i]), 32'(es[0]));
      chk($sformatf("u%0d.fstart", i), 32'(fs[i]), 32'(efs));
`ifdef FRAME_COUNT_EN
      chk($sformatf("u%0d.fcount", i), 32'(fc[i]), 32'(efc));
`endif
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    in_rst = 1'b0;
    k = 0;
    check_all();
  endtask

  initial begin
    cfg[0] = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 1};
    cfg[1] = '{2, 8, 2, 3, 2, 6, 1, 2, 1, 0};
    cfg[2] = '{3, 5, 1, 2, 1, 3, 1, 1, 1, 3};
    repeat (3) @(negedge clk);
    check_all();
    release_rst();
    run(3300);
    for (int r = 0; r < 3; r++) begin
      run(int'($urandom_range(2000, 50)));
      #(1 + ($urandom % 3));
      rst = 1'b1;
      in_rst = 1'b1;
      #1;
      check_all();
      @(negedge clk);
      check_all();
      release_rst();
    end
    run(1000);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
